// File: rtl/axi_stream_packet_master.sv
// AXI4-Stream transmitter: frames a valid/ready word source into packets (TLAST from
// beat count or flush, TID latched at packet start) behind a fully registered 2-entry skid buffer.
module axi_stream_packet_master #(
  parameter int byte_width = 4,
  parameter int id_width   = 2,
  parameter int len_width  = 8,
  parameter int cnt_width  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*byte_width-1:0] in_data,
  input  logic [byte_width-1:0]   in_keep,
  input  logic                    in_flush,
  input  logic [len_width-1:0]    cfg_len,
  input  logic [id_width-1:0]     cfg_id,
  output logic                    tvalid,
  input  logic                    tready,
  output logic [8*byte_width-1:0] tdata,
  output logic [byte_width-1:0]   tstrb,
  output logic [byte_width-1:0]   tkeep,
  output logic                    tlast,
  output logic [id_width-1:0]     tid,
  output logic [cnt_width-1:0]    pkt_count,
  output logic                    busy
);

  localparam int dw = 8 * byte_width;

  // Handshakes: a transfer happens on a rising edge where valid && ready. A valid, once
  // raised, is held with its payload frozen until that transfer; ready never depends
  // combinationally on the other side's valid or ready.

  logic [len_width-1:0] beat_cnt;
  logic [len_width-1:0] len_q;
  logic [len_width-1:0] cur_len;
  logic [id_width-1:0]  id_q;
  logic [id_width-1:0]  cur_id;
  logic                 accept;
  logic                 cur_last;
  logic                 out_free;
  logic                 skid_valid;
  logic                 skid_valid_next;
  logic [dw-1:0]        skid_data;
  logic [byte_width-1:0] skid_keep;
  logic                 skid_last;
  logic [id_width-1:0]  skid_id;

  always_comb begin
    accept   = in_valid && in_ready;
    cur_len  = (beat_cnt == '0) ? cfg_len : len_q;
    cur_id   = (beat_cnt == '0) ? cfg_id : id_q;
    // cfg_len of 0 wraps to all-ones here, giving a 2^len_width beat packet.
    cur_last = in_flush || (beat_cnt == (cur_len - len_width'(1)));
    out_free = !tvalid || tready;
    skid_valid_next = out_free ? 1'b0 : (skid_valid || accept);
  end

  assign tstrb = tkeep;
  assign busy  = (beat_cnt != '0) || tvalid || skid_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b0;
      beat_cnt   <= '0;
      len_q      <= '0;
      id_q       <= '0;
      tvalid     <= 1'b0;
      tdata      <= '0;
      tkeep      <= '0;
      tlast      <= 1'b0;
      tid        <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      skid_id    <= '0;
      pkt_count  <= '0;
    end else begin
      in_ready   <= !skid_valid_next;
      skid_valid <= skid_valid_next;

      if (accept) begin
        beat_cnt <= cur_last ? '0 : beat_cnt + len_width'(1);
        if (beat_cnt == '0) begin
          len_q <= cfg_len;
          id_q  <= cfg_id;
        end
      end

      // Skid content is older than any new word, so it drains to the output first.
      if (out_free) begin
        if (skid_valid) begin
          tvalid <= 1'b1;
          tdata  <= skid_data;
          tkeep  <= skid_keep;
          tlast  <= skid_last;
          tid    <= skid_id;
        end else if (accept) begin
          tvalid <= 1'b1;
          tdata  <= in_data;
          tkeep  <= in_keep;
          tlast  <= cur_last;
          tid    <= cur_id;
        end else begin
          tvalid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= in_data;
        skid_keep <= in_keep;
        skid_last <= cur_last;
        skid_id   <= cur_id;
      end

      if (tvalid && tready && tlast)
        pkt_count <= pkt_count + cnt_width'(1);
    end
  end

endmodule

// File: tb/tb_axi_stream_packet_master.sv
// Directed bench for axi_stream_packet_master: stimulus pushes hand-computed beats into
// a queue, an independent monitor pops and compares on every output handshake.
module tb_axi_stream_packet_master;
  localparam int BW = 4;
  localparam int IW = 2;
  localparam int LW = 8;
  localparam int CW = 4;
  localparam int DW = 8 * BW;
  localparam int EW = 1 + IW + BW + DW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [BW-1:0] in_keep;
  logic          in_flush;
  logic [LW-1:0] cfg_len;
  logic [IW-1:0] cfg_id;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic [BW-1:0] tstrb;
  logic [BW-1:0] tkeep;
  logic          tlast;
  logic [IW-1:0] tid;
  logic [CW-1:0] pkt_count;
  logic          busy;

  axi_stream_packet_master #(
    .byte_width(BW), .id_width(IW), .len_width(LW), .cnt_width(CW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_flush(in_flush),
    .cfg_len(cfg_len), .cfg_id(cfg_id), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid),
    .pkt_count(pkt_count), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic f,
                      input logic el, input logic [IW-1:0] eid);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_keep = k; in_flush = f;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("send_wait_in_ready");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({el, eid, k, d});
      #1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while ((exp_q.size() != 0 || tvalid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || tvalid) fail_now("drain");
    check("busy_idle", busy, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor, sampled 1 time unit before each rising edge
  logic          prev_stall;
  logic [EW-1:0] word;
  logic [EW-1:0] prev_word;
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        word = {tlast, tid, tkeep, tdata};
        if (prev_stall) begin
          check("hold_tvalid", tvalid, 1'b1);
          check("hold_payload", 64'(word), 64'(prev_word));
        end
        if (tvalid) check("tstrb_eq_tkeep", tstrb, tkeep);
        if (tvalid && tready) begin
          if (exp_q.size() == 0) fail_now("unexpected_beat");
          else check("beat", 64'(word), 64'(exp_q.pop_front()));
        end
        prev_stall = tvalid && !tready;
        prev_word  = word;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    checks++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_flush = 1'b0;
    cfg_len = 8'd4; cfg_id = 2'd1; tready = 1'b1;
    #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_pkt_count", pkt_count, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_tdata", tdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("release_in_ready_high", in_ready, 1'b1);

    // 1: two 4-beat packets back to back, varied keep
    check("t1_tvalid_before", tvalid, 1'b0);
    send(32'd0, 4'hF, 1'b0, 1'b0, 2'd1);
    check("t1_latency_tvalid", tvalid, 1'b1);
    for (int i = 1; i < 8; i++)
      send(32'(i), 4'(i * 3 + 1), 1'b0, (i == 3) || (i == 7), 2'd1);
    drain();
    check("t1_pkt_count", pkt_count, 4'd2);

    // 2: back-pressure for 3 cycles after first tvalid
    cfg_len = 8'd5; cfg_id = 2'd2; tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'h20 + 32'(i), 4'hF, 1'b0, i == 4, 2'd2);
        idle();
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!tvalid && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!tvalid) fail_now("t2_wait_tvalid");
        @(negedge clk);
        check("t2_in_ready_drop", in_ready, 1'b0);
        check("t2_tdata_held", tdata, 32'h20);
        @(negedge clk);
        @(negedge clk);
        tready = 1'b1;
      end
    join
    drain();
    check("t2_pkt_count", pkt_count, 4'd3);

    // 3: flush on beat 1, then flush coinciding with natural last
    cfg_len = 8'd4; cfg_id = 2'd0;
    send(32'h30, 4'hF, 1'b0, 1'b0, 2'd0);
    send(32'h31, 4'hF, 1'b1, 1'b1, 2'd0);
    send(32'h32, 4'hF, 1'b0, 1'b0, 2'd0);
    send(32'h33, 4'hF, 1'b0, 1'b0, 2'd0);
    send(32'h34, 4'hF, 1'b0, 1'b0, 2'd0);
    send(32'h35, 4'hF, 1'b1, 1'b1, 2'd0);
    for (int i = 6; i < 10; i++) send(32'h30 + 32'(i), 4'hF, 1'b0, i == 9, 2'd0);
    drain();
    check("t3_pkt_count", pkt_count, 4'd6);

    // 4: mid-packet config change, then 256-beat packet from cfg_len=0
    cfg_len = 8'd4; cfg_id = 2'd1;
    send(32'h40, 4'hF, 1'b0, 1'b0, 2'd1);
    send(32'h41, 4'hF, 1'b0, 1'b0, 2'd1);
    cfg_len = 8'd2; cfg_id = 2'd3;
    send(32'h42, 4'hF, 1'b0, 1'b0, 2'd1);
    send(32'h43, 4'hF, 1'b0, 1'b1, 2'd1);
    send(32'h44, 4'hF, 1'b0, 1'b0, 2'd3);
    send(32'h45, 4'hF, 1'b0, 1'b1, 2'd3);
    drain();
    check("t4_pkt_count_a", pkt_count, 4'd8);
    cfg_len = 8'd0; cfg_id = 2'd2;
    for (int i = 0; i < 256; i++) send(32'h100 + 32'(i), 4'hF, 1'b0, i == 255, 2'd2);
    drain();
    check("t4_pkt_count_b", pkt_count, 4'd9);

    // 5: asynchronous reset mid-packet while tvalid is high
    cfg_len = 8'd4; cfg_id = 2'd1;
    send(32'h50, 4'hF, 1'b0, 1'b0, 2'd1);
    send(32'h51, 4'hF, 1'b0, 1'b0, 2'd1);
    check("t5_tvalid_before_reset", tvalid, 1'b1);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t5_tvalid_async", tvalid, 1'b0);
    check("t5_in_ready_async", in_ready, 1'b0);
    check("t5_pkt_count_async", pkt_count, 4'd0);
    check("t5_busy_async", busy, 1'b0);
    check("t5_tlast_async", tlast, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_in_ready_release", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("t5_in_ready_edge", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h52 + 32'(i), 4'hF, 1'b0, i == 3, 2'd1);
    drain();
    check("t5_pkt_count", pkt_count, 4'd1);

    // 6: single-beat packets wrap the 4-bit packet counter
    pulse_reset();
    check("t6_pkt_count_reset", pkt_count, 4'd0);
    cfg_len = 8'd1; cfg_id = 2'd3;
    for (int i = 0; i < 17; i++) send(32'h60 + 32'(i), 4'hF, 1'b0, 1'b1, 2'd3);
    drain();
    check("t6_pkt_count_wrap", pkt_count, 4'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
